// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates 256 saturating bins per image, then streams
// every bin downstream with a valid/ready handshake and flags completion.
module lbp_hist (
   input  logic        clk,
   input  logic        reset,
   input  logic        lbp_valid,
   input  logic [13:0] lbp_addr,
   input  logic [7:0]  lbp_data,
   input  logic        finish,
   input  logic        hist_ready,
   output logic        hist_valid,
   output logic [7:0]  hist_bin,
   output logic [13:0] hist_count,
   output logic [13:0] sample_total,
   output logic        done
);

   localparam logic [13:0] CountMax = 14'h3FFF;
   localparam logic [7:0]  LastBin  = 8'hFF;

   typedef enum logic [1:0] {StAccum, StDump, StDone} state_e;

   state_e      state_q, state_d;
   logic [13:0] bin_q [256];
   logic [13:0] total_q;
   logic [13:0] last_addr_q;
   logic        addr_vld_q;
   logic [7:0]  bin_idx_q, bin_idx_d;
   logic        count;

   // A held lbp_valid repeats the same address; only a new address is a new sample.
   assign count = (state_q == StAccum) && lbp_valid &&
                  (!addr_vld_q || (lbp_addr != last_addr_q));

   always_comb begin
      state_d   = state_q;
      bin_idx_d = bin_idx_q;
      unique case (state_q)
         StAccum: begin
            if (finish) begin
               state_d = StDump;
            end
         end
         StDump: begin
            if (hist_ready) begin
               if (bin_idx_q == LastBin) begin
                  state_d = StDone;
               end else begin
                  bin_idx_d = bin_idx_q + 8'd1;
               end
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StAccum;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StAccum;
         bin_idx_q   <= 8'd0;
         total_q     <= 14'd0;
         last_addr_q <= 14'd0;
         addr_vld_q  <= 1'b0;
         for (int i = 0; i < 256; i++) begin
            bin_q[i] <= 14'd0;
         end
      end else begin
         state_q   <= state_d;
         bin_idx_q <= bin_idx_d;
         if (count) begin
            if (bin_q[lbp_data] != CountMax) begin
               bin_q[lbp_data] <= bin_q[lbp_data] + 14'd1;
            end
            if (total_q != CountMax) begin
               total_q <= total_q + 14'd1;
            end
            last_addr_q <= lbp_addr;
            addr_vld_q  <= 1'b1;
         end
      end
   end

   // Bin read is indexed by a register only, so no input reaches hist_count.
   assign hist_count   = bin_q[bin_idx_q];
   assign hist_bin     = bin_idx_q;
   assign hist_valid   = (state_q == StDump);
   assign done         = (state_q == StDone);
   assign sample_total = total_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist: table-driven accumulation checks plus a
// scoreboard of expected bins consumed as the DUT streams them out.
module tb_lbp_hist;

   logic        clk = 1'b0;
   logic        reset;
   logic        lbp_valid;
   logic [13:0] lbp_addr;
   logic [7:0]  lbp_data;
   logic        finish;
   logic        hist_ready;
   logic        hist_valid;
   logic [7:0]  hist_bin;
   logic [13:0] hist_count;
   logic [13:0] sample_total;
   logic        done;

   always #5 clk = ~clk;

   lbp_hist dut (
      .clk         (clk),
      .reset       (reset),
      .lbp_valid   (lbp_valid),
      .lbp_addr    (lbp_addr),
      .lbp_data    (lbp_data),
      .finish      (finish),
      .hist_ready  (hist_ready),
      .hist_valid  (hist_valid),
      .hist_bin    (hist_bin),
      .hist_count  (hist_count),
      .sample_total(sample_total),
      .done        (done)
   );

   typedef struct {
      logic [7:0]  bin;
      logic [13:0] count;
   } xfer_t;

   typedef struct {
      logic        v;
      logic [13:0] addr;
      logic [7:0]  data;
      int          exp_total;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   int    exp_bin [256];
   int    exp_total;
   xfer_t sb_q [$];
   vec_t  vecs [9];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_add(input int data);
      if (exp_bin[data] < 16383) exp_bin[data]++;
      if (exp_total < 16383) exp_total++;
   endtask

   task automatic push_expected();
      xfer_t e;
      for (int b = 0; b < 256; b++) begin
         e.bin   = 8'(b);
         e.count = 14'(exp_bin[b]);
         sb_q.push_back(e);
      end
   endtask

   // Reset with lbp_valid high to confirm it is ignored while reset is low.
   task automatic do_reset();
      reset      = 1'b0;
      lbp_valid  = 1'b1;
      lbp_addr   = 14'd7;
      lbp_data   = 8'd3;
      finish     = 1'b0;
      hist_ready = 1'b0;
      tick();
      check("rst_total", sample_total, 0);
      check("rst_valid", hist_valid, 0);
      check("rst_done", done, 0);
      check("rst_bin", hist_bin, 0);
      reset     = 1'b1;
      lbp_valid = 1'b0;
      for (int b = 0; b < 256; b++) exp_bin[b] = 0;
      exp_total = 0;
      sb_q.delete();
   endtask

   // Drains the scoreboard; stall=1 applies ready 1,0,0,1 over the first cycles.
   task automatic dump(input int stall, input int stop_at, output int sum);
      int    xfers;
      int    cycles;
      int    vcycles;
      xfer_t e;
      xfers   = 0;
      cycles  = 0;
      vcycles = 0;
      sum     = 0;
      while (xfers < stop_at && cycles < 2000) begin
         hist_ready = !(stall != 0 && (cycles == 1 || cycles == 2));
         if (hist_valid) vcycles++;
         if (hist_valid && hist_ready) begin
            check("sb_size", sb_q.size(), 256 - xfers);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("dump_bin", hist_bin, e.bin);
               check("dump_count", hist_count, e.count);
            end
            sum += hist_count;
            xfers++;
         end else if (hist_valid) begin
            check("held_bin", hist_bin, 1);
            check("held_count", hist_count, exp_bin[1]);
         end
         tick();
         cycles++;
      end
      check("xfers", xfers, stop_at);
      if (stop_at == 256) begin
         check("valid_cycles", vcycles, (stall != 0) ? 258 : 256);
         check("done_after_255", done, 1);
         check("valid_after_255", hist_valid, 0);
         hist_ready = 1'b1;
         tick();
         check("done_hold", done, 1);
         check("no_wrap", hist_bin, 255);
      end
   endtask

   initial begin
      int sum;
      int prev;
      reset      = 1'b0;
      lbp_valid  = 1'b0;
      lbp_addr   = 14'd0;
      lbp_data   = 8'd0;
      finish     = 1'b0;
      hist_ready = 1'b0;
      tick();
      do_reset();

      // Held valid counts once; repeated address with new data is not a new sample.
      vecs[0] = '{1'b1, 14'd129, 8'h5A, 1};
      vecs[1] = '{1'b1, 14'd129, 8'h5A, 1};
      vecs[2] = '{1'b1, 14'd129, 8'h5A, 1};
      vecs[3] = '{1'b0, 14'd130, 8'h11, 1};
      vecs[4] = '{1'b1, 14'd130, 8'h11, 2};
      vecs[5] = '{1'b1, 14'd131, 8'h00, 3};
      vecs[6] = '{1'b1, 14'd131, 8'h77, 3};
      vecs[7] = '{1'b1, 14'd129, 8'h22, 4};
      vecs[8] = '{1'b0, 14'd129, 8'h22, 4};
      prev = 0;
      for (int i = 0; i < 9; i++) begin
         lbp_valid = vecs[i].v;
         lbp_addr  = vecs[i].addr;
         lbp_data  = vecs[i].data;
         tick();
         check($sformatf("vec%0d_total", i), sample_total, vecs[i].exp_total);
         if (vecs[i].exp_total > prev) exp_bin[vecs[i].data]++;
         prev = vecs[i].exp_total;
      end
      lbp_valid = 1'b0;
      finish    = 1'b1;
      tick();
      check("t1_enter_dump", hist_valid, 1);
      push_expected();
      dump(1, 256, sum);
      check("t1_sum", sum, 4);

      // Full 126x126 interior image, lbp_valid held high throughout.
      do_reset();
      for (int r = 1; r <= 126; r++) begin
         for (int c = 1; c <= 126; c++) begin
            lbp_valid = 1'b1;
            lbp_addr  = 14'(r * 128 + c);
            lbp_data  = 8'(r * 7 + c * 13);
            model_add(int'(lbp_data));
            tick();
         end
      end
      lbp_valid = 1'b0;
      finish    = 1'b1;
      tick();
      check("img_total", sample_total, 15876);
      check("img_enter_dump", hist_valid, 1);
      push_expected();
      dump(0, 256, sum);
      check("img_sum", sum, 15876);

      // Sample and finish in the same cycle.
      do_reset();
      lbp_valid = 1'b1;
      lbp_addr  = 14'd5;
      lbp_data  = 8'hFF;
      finish    = 1'b1;
      model_add(255);
      tick();
      lbp_valid = 1'b0;
      check("same_cyc_dump", hist_valid, 1);
      check("same_cyc_total", sample_total, 1);
      push_expected();
      dump(0, 256, sum);
      check("same_cyc_sum", sum, 1);

      // Saturation of bin 0 and sample_total.
      do_reset();
      for (int i = 0; i < 16400; i++) begin
         lbp_valid = 1'b1;
         lbp_addr  = 14'(i);
         lbp_data  = 8'h00;
         model_add(0);
         tick();
      end
      lbp_valid = 1'b0;
      check("sat_total", sample_total, 16383);
      check("sat_model", exp_bin[0], 16383);
      finish = 1'b1;
      tick();
      push_expected();
      dump(0, 256, sum);
      check("sat_sum", sum, 16383);

      // Reset in the middle of DUMP, then an empty image.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         lbp_valid = 1'b1;
         lbp_addr  = 14'(1000 + i);
         lbp_data  = 8'(i * 20);
         model_add(i * 20);
         tick();
      end
      lbp_valid = 1'b0;
      finish    = 1'b1;
      tick();
      push_expected();
      dump(0, 100, sum);
      check("mid_bin", hist_bin, 100);
      check("mid_valid", hist_valid, 1);
      do_reset();
      tick();
      check("accum_valid", hist_valid, 0);
      check("accum_done", done, 0);
      finish = 1'b1;
      tick();
      check("empty_enter_dump", hist_valid, 1);
      push_expected();
      dump(0, 256, sum);
      check("empty_sum", sum, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
